sha1_exec_par: RTL and testbench
================================

Name: sha1_exec_par

Overview:
- Parametrised next-generation SHA-1 compression core. Processes one 512-bit block per operation.
- Performs ROUNDS_PER_CLK rounds per clock, trading area for latency.
- Message words arrive through a valid/ready stream. The digest leaves through a valid/ready output that holds under backpressure.
- Supports chaining from its own previous digest, block abort, and a processed-block counter. Sits under an HMAC/padding wrapper.

Parameters:
- ROUNDS_PER_CLK, 1: SHA-1 rounds per CALC cycle. Legal values are 1, 2, 4, 5, 8, 10, 16, 20. Any value where 80 % ROUNDS_PER_CLK != 0 is an elaboration error.

Ports:
- clk  in  1  clock. Interface: one clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- msg_valid  in  1  msg_data holds a message word.
- msg_ready  out  1  core accepts a word this cycle.
- msg_data  in  32  message word, big-endian word order, W0 first.
- cv_in  in  160  external chaining value {A,B,C,D,E}.
- use_prev_cv  in  1  1 selects hash_out as the chaining value, 0 selects cv_in.
- abort  in  1  synchronous block discard.
- busy  out  1  high in CALC and FINAL.
- hash_valid  out  1  digest available.
- hash_ready  in  1  consumer accepts the digest.
- hash_out  out  160  registered digest, held until the next FINAL.
- blk_cnt  out  32  count of completed blocks.

Behaviour:
- Reset values (asynchronous): state=LOAD, word_cnt=0, round_cnt=0, msg_ready=1, busy=0, hash_valid=0, hash_out=0, blk_cnt=0, all working registers 0.
- Handshake definitions:
  - A word transfers on a rising edge with msg_valid & msg_ready.
  - A digest transfers on a rising edge with hash_valid & hash_ready.
- Outputs are decoded from state only: msg_ready=(LOAD), busy=(CALC|FINAL), hash_valid=(OUT).
- LOAD state:
  - Each transfer shifts msg_data into a 16x32 window and increments word_cnt.
  - On word 0 the core samples use_prev_cv. It loads the A..E working regs and the saved CV from hash_out (use_prev_cv=1) or cv_in (use_prev_cv=0).
  - Both inputs are ignored on words 1..15.
  - On the transfer of word 15: word_cnt goes to 0 and state goes to CALC.
  - msg_valid gaps are allowed.
- CALC state:
  - Each cycle performs rounds t=round_cnt..round_cnt+ROUNDS_PER_CLK-1 combinationally chained, then round_cnt += ROUNDS_PER_CLK.
  - f and K by t: 0-19 Ch, 5A827999; 20-39 Parity, 6ED9EBA1; 40-59 Maj, 8F1BBCDC; 60-79 Parity, CA62C1D6.
  - For t>=16: W_t = ROTL1(W_t-3 ^ W_t-8 ^ W_t-14 ^ W_t-16). The window advances ROUNDS_PER_CLK words per cycle.
  - When round_cnt + ROUNDS_PER_CLK == 80: state goes to FINAL and round_cnt goes to 0.
- FINAL state (1 cycle):
  - hash_out <= per-word mod-2^32 sum of saved CV and A..E.
  - blk_cnt += 1, wrapping FFFFFFFF to 0.
  - State goes to OUT.
- OUT state:
  - hash_valid=1 and hash_out is stable until the transfer.
  - On transfer the state goes to LOAD.
  - hash_out keeps its value after the transfer so the next block can chain from it.
- Latency: hash_valid rises 80/ROUNDS_PER_CLK + 1 edges after the edge accepting word 15. This is 81 edges at the default.
- Throughput: 16 + 80/ROUNDS_PER_CLK + 2 cycles per block, minimum.
- Abort rules:
  - Abort sampled high in LOAD, CALC or FINAL: the next state is LOAD and word_cnt/round_cnt clear.
  - The partial block is discarded; hash_out and blk_cnt are unchanged.
  - Abort has priority over a simultaneous word transfer or the FINAL update.
  - Abort in OUT is ignored, and the digest handshake completes normally.
- Boundary conditions:
  - use_prev_cv=1 before any block completes chains from 0. This is legal and not checked.
  - hash_ready held high outside OUT has no effect.
  - A reset_n assertion at any time forces reset values immediately. The current block is lost.

Test Plan:
1. ROUNDS_PER_CLK=1. Block "abc": 61626380, 14x00000000, 00000018. cv_in=67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0, use_prev_cv=0 -> hash_out=A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D. hash_valid rises 81 edges after the word-15 transfer. blk_cnt=1.
2. Repeat test 1 with ROUNDS_PER_CLK=4, 5 and 20 -> same digest, latency 21, 17 and 5 edges. busy high exactly 20, 16 and 4 CALC cycles plus 1 FINAL.
3. Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq". Block 1 uses cv_in=H0; block 2 uses use_prev_cv=1 with padding and length 000001C0 -> hash_out=84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1, blk_cnt=2.
4. Backpressure and gaps: random msg_valid gaps, then hash_ready held low 10 cycles -> hash_valid and hash_out stable, msg_ready=0 throughout. One cycle after the transfer, msg_ready=1.
5. Abort cases, then the "abc" block -> correct digest in every case:
   - abort after 7 words: msg_ready stays 1 and the next word is treated as W0.
   - abort at CALC round 40: hash_out and blk_cnt are unchanged.
   - abort together with hash_ready in OUT: the transfer completes.
6. Drive reset_n low mid-CALC between edges -> busy=0, hash_out=0 and msg_ready=1 immediately. After release, the "abc" block gives the test 1 digest and blk_cnt=1.

Source files
------------

// File: rtl/sha1_exec_par.sv
// SHA-1 compression core, ROUNDS_PER_CLK rounds per CALC cycle.
// Streams 16 words in, emits a held 160-bit digest with a block counter.
module sha1_exec_par #(
  parameter int ROUNDS_PER_CLK = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic [159:0] cv_in,
  input  logic         use_prev_cv,
  input  logic         abort,
  output logic         busy,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [159:0] hash_out,
  output logic [31:0]  blk_cnt
);

  localparam int R = ROUNDS_PER_CLK;

  if (R < 1 || 80 % R != 0) begin : g_bad_rpc
    $error("ROUNDS_PER_CLK must divide 80");
  end

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]   word_cnt;
  logic [6:0]   round_cnt;
  logic [31:0]  win [16];
  logic [31:0]  win_nx [16];
  logic [31:0]  a, b, c, d, e;
  logic [31:0]  a_nx, b_nx, c_nx, d_nx, e_nx;
  logic [159:0] cv_sv;
  logic [159:0] cv_sel;
  logic         xfer;
  logic         hxfer;
  logic         calc_last;
  logic         kill;

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input int          n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_fn(
    input logic [6:0]  t,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    logic [31:0] r;
    if (t < 7'd20)      r = (x & y) | (~x & z);
    else if (t < 7'd40) r = x ^ y ^ z;
    else if (t < 7'd60) r = (x & y) | (x & z) | (y & z);
    else                r = x ^ y ^ z;
    return r;
  endfunction

  function automatic logic [31:0] k_fn(input logic [6:0] t);
    logic [31:0] r;
    if (t < 7'd20)      r = 32'h5A827999;
    else if (t < 7'd40) r = 32'h6ED9EBA1;
    else if (t < 7'd60) r = 32'h8F1BBCDC;
    else                r = 32'hCA62C1D6;
    return r;
  endfunction

  assign xfer      = msg_valid & msg_ready;
  assign hxfer     = hash_valid & hash_ready;
  assign calc_last = ({1'b0, round_cnt} + 8'(R)) == 8'd80;
  assign kill      = abort & (state != OUT);
  assign cv_sel    = use_prev_cv ? hash_out : cv_in;

  // R chained rounds; window slot 0 always holds W_t of the current round
  always_comb begin : p_rounds
    logic [31:0] ta, tb, tc, td, te, tmp, nw;
    logic [31:0] tw [16];
    logic [6:0]  t;
    ta = a;
    tb = b;
    tc = c;
    td = d;
    te = e;
    tw = win;
    for (int i = 0; i < R; i++) begin
      t   = round_cnt + 7'(i);
      tmp = rotl(ta, 5) + f_fn(t, tb, tc, td) + te + k_fn(t) + tw[0];
      nw  = rotl(tw[13] ^ tw[8] ^ tw[2] ^ tw[0], 1);
      te  = td;
      td  = tc;
      tc  = rotl(tb, 30);
      tb  = ta;
      ta  = tmp;
      for (int j = 0; j < 15; j++) tw[j] = tw[j+1];
      tw[15] = nw;
    end
    a_nx   = ta;
    b_nx   = tb;
    c_nx   = tc;
    d_nx   = td;
    e_nx   = te;
    win_nx = tw;
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nx;
  end

  // next-state decode; abort wins everywhere except OUT
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: begin
        if (abort)                          state_nx = LOAD;
        else if (xfer && word_cnt == 4'd15) state_nx = CALC;
      end
      CALC: begin
        if (abort)          state_nx = LOAD;
        else if (calc_last) state_nx = FINAL;
      end
      FINAL: state_nx = abort ? LOAD : OUT;
      OUT:   if (hxfer) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // outputs decoded from state only
  always_comb begin
    msg_ready  = (state == LOAD);
    busy       = (state == CALC) || (state == FINAL);
    hash_valid = (state == OUT);
  end

  // datapath: window load, round updates, digest and counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt  <= '0;
      round_cnt <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      e         <= '0;
      cv_sv     <= '0;
      hash_out  <= '0;
      blk_cnt   <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (kill) begin
      word_cnt  <= '0;
      round_cnt <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (xfer) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15]  <= msg_data;
            word_cnt <= word_cnt + 4'd1;
            if (word_cnt == 4'd0) begin
              a     <= cv_sel[159:128];
              b     <= cv_sel[127:96];
              c     <= cv_sel[95:64];
              d     <= cv_sel[63:32];
              e     <= cv_sel[31:0];
              cv_sv <= cv_sel;
            end
          end
        end
        CALC: begin
          a   <= a_nx;
          b   <= b_nx;
          c   <= c_nx;
          d   <= d_nx;
          e   <= e_nx;
          win <= win_nx;
          round_cnt <= calc_last ? 7'd0 : round_cnt + 7'(R);
        end
        FINAL: begin
          hash_out <= {cv_sv[159:128] + a,
                       cv_sv[127:96]  + b,
                       cv_sv[95:64]   + c,
                       cv_sv[63:32]   + d,
                       cv_sv[31:0]    + e};
          blk_cnt  <= blk_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_exec_par.sv
// Directed bench for sha1_exec_par: FIPS 180 vectors at several
// round widths, backpressure, abort and mid-block reset.
module tb_sha1_exec_par;

  localparam int NI = 4;
  localparam int RPC [NI] = '{1, 4, 5, 20};

  localparam logic [159:0] H0 =
    160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
  localparam logic [159:0] D_ABC =
    160'hA9993E364706816ABA3E25717850C26C9CD0D89D;
  localparam logic [159:0] D_TWO =
    160'h84983E441C3BD26EBAAE4AA1F95129E5E54670F1;

  logic clk;
  logic reset_n;

  logic         msg_valid  [NI];
  logic [31:0]  msg_data   [NI];
  logic         use_prev   [NI];
  logic         abort_i    [NI];
  logic         hash_ready [NI];
  logic         msg_ready  [NI];
  logic         busy       [NI];
  logic         hash_valid [NI];
  logic [159:0] hash_out   [NI];
  logic [31:0]  blk_cnt    [NI];

  logic [31:0] blks [3][16];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha1_exec_par #(.ROUNDS_PER_CLK(RPC[g])) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .msg_valid   (msg_valid[g]),
      .msg_ready   (msg_ready[g]),
      .msg_data    (msg_data[g]),
      .cv_in       (H0),
      .use_prev_cv (use_prev[g]),
      .abort       (abort_i[g]),
      .busy        (busy[g]),
      .hash_valid  (hash_valid[g]),
      .hash_ready  (hash_ready[g]),
      .hash_out    (hash_out[g]),
      .blk_cnt     (blk_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [159:0] got,
    input logic [159:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put_word(
    input int          k,
    input logic [31:0] dat,
    input logic        prev,
    input int          gap
  );
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    msg_valid[k] = 1'b1;
    msg_data[k]  = dat;
    use_prev[k]  = prev;
    while (!msg_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!msg_ready[k]) chk("ready_timeout", 160'(0), 160'(1));
    @(posedge clk);
    #1;
    msg_valid[k] = 1'b0;
  endtask

  task automatic send_block(
    input int   k,
    input int   sel,
    input logic prev,
    input int   maxgap
  );
    for (int i = 0; i < 16; i++)
      put_word(k, blks[sel][i], prev,
               maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // edges from the word-15 edge to hash_valid, and busy samples
  task automatic wait_digest(
    input  int k,
    output int lat,
    output int bsy
  );
    lat = 0;
    bsy = busy[k] ? 1 : 0;
    while (!hash_valid[k] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy[k]) bsy++;
    end
    if (!hash_valid[k]) chk("digest_timeout", 160'(0), 160'(1));
  endtask

  task automatic take_digest(input int k);
    @(negedge clk);
    hash_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    hash_ready[k] = 1'b0;
    chk("ready_after_take", 160'(msg_ready[k]), 160'(1));
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int lat, bsy;

  initial begin
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++) blks[s][i] = 32'h0;
    blks[0][0]  = 32'h61626380;
    blks[0][15] = 32'h00000018;
    blks[1][0]  = 32'h61626364; blks[1][1]  = 32'h62636465;
    blks[1][2]  = 32'h63646566; blks[1][3]  = 32'h64656667;
    blks[1][4]  = 32'h65666768; blks[1][5]  = 32'h66676869;
    blks[1][6]  = 32'h6768696A; blks[1][7]  = 32'h68696A6B;
    blks[1][8]  = 32'h696A6B6C; blks[1][9]  = 32'h6A6B6C6D;
    blks[1][10] = 32'h6B6C6D6E; blks[1][11] = 32'h6C6D6E6F;
    blks[1][12] = 32'h6D6E6F70; blks[1][13] = 32'h6E6F7071;
    blks[1][14] = 32'h80000000; blks[1][15] = 32'h00000000;
    blks[2][15] = 32'h000001C0;

    for (int k = 0; k < NI; k++) begin
      msg_valid[k]  = 1'b0;
      msg_data[k]   = 32'h0;
      use_prev[k]   = 1'b0;
      abort_i[k]    = 1'b0;
      hash_ready[k] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_flags", 160'({msg_ready[0], busy[0], hash_valid[0]}),
        160'(3'b100));
    chk("rst_hash", hash_out[0], 160'(0));
    chk("rst_blk", 160'(blk_cnt[0]), 160'(0));
    reset_n = 1'b1;

    // single "abc" block at one round per clock
    send_block(0, 0, 1'b0, 0);
    wait_digest(0, lat, bsy);
    chk("t1_digest", hash_out[0], D_ABC);
    chk("t1_latency", 160'(lat), 160'(81));
    chk("t1_busy", 160'(bsy), 160'(81));
    chk("t1_blk", 160'(blk_cnt[0]), 160'(1));
    take_digest(0);

    // wider round datapaths; instance 1 keeps hash_ready high
    for (int k = 1; k < NI; k++) begin
      if (k == 1) hash_ready[1] = 1'b1;
      send_block(k, 0, 1'b0, 0);
      wait_digest(k, lat, bsy);
      chk("t2_digest", hash_out[k], D_ABC);
      chk("t2_latency", 160'(lat), 160'(80 / RPC[k] + 1));
      chk("t2_busy", 160'(bsy), 160'(80 / RPC[k] + 1));
      chk("t2_blk", 160'(blk_cnt[k]), 160'(1));
      if (k == 1) begin
        @(posedge clk);
        #1;
        hash_ready[1] = 1'b0;
        chk("t2_auto_take", 160'(msg_ready[1]), 160'(1));
      end else begin
        take_digest(k);
      end
    end

    // two-block message chained through hash_out
    do_reset();
    send_block(0, 1, 1'b0, 0);
    wait_digest(0, lat, bsy);
    take_digest(0);
    send_block(0, 2, 1'b1, 0);
    wait_digest(0, lat, bsy);
    chk("t3_digest", hash_out[0], D_TWO);
    chk("t3_blk", 160'(blk_cnt[0]), 160'(2));
    take_digest(0);

    // gaps on the input, then consumer backpressure
    send_block(0, 0, 1'b0, 3);
    wait_digest(0, lat, bsy);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t4_hold_flags", 160'({hash_valid[0], msg_ready[0]}),
          160'(2'b10));
      chk("t4_hold_hash", hash_out[0], D_ABC);
    end
    take_digest(0);
    chk("t4_blk", 160'(blk_cnt[0]), 160'(3));

    // abort after 7 words, then a clean block
    do_reset();
    for (int i = 0; i < 7; i++) put_word(0, 32'hDEADBEEF, 1'b0, 0);
    @(negedge clk);
    abort_i[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_i[0] = 1'b0;
    chk("t5_abort_load_ready", 160'(msg_ready[0]), 160'(1));
    send_block(0, 0, 1'b0, 0);
    wait_digest(0, lat, bsy);
    chk("t5_digest_a", hash_out[0], D_ABC);
    chk("t5_blk_a", 160'(blk_cnt[0]), 160'(1));
    take_digest(0);

    // abort at round 40 with a different block in flight
    send_block(0, 1, 1'b0, 0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    abort_i[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_i[0] = 1'b0;
    chk("t5_abort_calc_flags", 160'({msg_ready[0], busy[0]}),
        160'(2'b10));
    chk("t5_abort_calc_hash", hash_out[0], D_ABC);
    chk("t5_abort_calc_blk", 160'(blk_cnt[0]), 160'(1));
    repeat (90) @(posedge clk);
    #1;
    chk("t5_no_late_digest", 160'({hash_valid[0], blk_cnt[0]}),
        160'({1'b0, 32'd1}));

    // abort together with the digest handshake
    send_block(0, 0, 1'b0, 0);
    wait_digest(0, lat, bsy);
    chk("t5_digest_b", hash_out[0], D_ABC);
    @(negedge clk);
    abort_i[0]    = 1'b1;
    hash_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_i[0]    = 1'b0;
    hash_ready[0] = 1'b0;
    chk("t5_abort_out_flags", 160'({msg_ready[0], hash_valid[0]}),
        160'(2'b10));
    chk("t5_abort_out_hash", hash_out[0], D_ABC);
    chk("t5_blk_b", 160'(blk_cnt[0]), 160'(2));

    // asynchronous reset in the middle of CALC
    send_block(0, 1, 1'b0, 0);
    repeat (30) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_flags", 160'({msg_ready[0], busy[0], hash_valid[0]}),
        160'(3'b100));
    chk("t6_rst_hash", hash_out[0], 160'(0));
    chk("t6_rst_blk", 160'(blk_cnt[0]), 160'(0));
    @(negedge clk);
    reset_n = 1'b1;
    send_block(0, 0, 1'b0, 0);
    wait_digest(0, lat, bsy);
    chk("t6_digest", hash_out[0], D_ABC);
    chk("t6_blk", 160'(blk_cnt[0]), 160'(1));
    take_digest(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
